mult_shift_8bits: RTL and testbench
===================================

Name: mult_shift_8bits

Overview:
- Sequential shift-and-add unsigned multiplier: 8-bit × 8-bit → 16-bit product, one multiplier bit per clock.
- Self-starting: no start strobe. The block captures M1/M2 after reset, and again whenever either operand changes.
- Flags completion with a level `ready`. Sits as a standalone arithmetic unit beside a simple controller or bench.

Parameters:
- WIDTH, 8, operand width; RESULT is 2*WIDTH bits. All values below assume WIDTH=8.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- M1  input  8  multiplicand, unsigned.
- M2  input  8  multiplier, unsigned.
- RESULT  output  16  product register, M1*M2.
- ready  output  1  high while RESULT holds the product of the currently latched operands.

Behaviour:
- Interface: one clock (CLK); RESET is synchronous and active-high. It is sampled only on the CLK rising edge and overrides everything else.
- Reset values: RESULT=0, ready=0, state=LOAD, counter=0, internal accumulator/shift registers=0.
- Internal registers:
  - A (16-bit shifted multiplicand).
  - B (8-bit shifted multiplier).
  - P (16-bit accumulator).
  - cnt (3-bit).
  - M1q/M2q (latched operand copies).
- LOAD (1 cycle): A<={8'b0,M1}, B<=M2, P<=0, cnt<=0, M1q<=M1, M2q<=M2, ready<=0. Next state: SHIFT.
- SHIFT (8 cycles):
  - Each edge: if B[0], P<=P+A; then A<=A<<1, B<=B>>1, cnt<=cnt+1.
  - On the edge with cnt==7: RESULT<=final sum (P plus A if B[0]), ready<=1, next state DONE.
- DONE: hold RESULT and ready=1 indefinitely.
- Operand change (SHIFT or DONE): if M1!==M1q or M2!==M2q, the next edge sets ready<=0 and state LOAD. The in-flight computation is abandoned.
  - Comparison is case-inequality, so undriven (X) inputs do not cause a spurious restart.
  - If inputs stay unknown, the result is whatever arithmetic on them yields; this is not required to be meaningful.
- RESULT is updated only on entry to DONE. During LOAD/SHIFT it keeps its previous value (0 after reset). ready=0 marks that value stale.
- Latency: first edge with RESET low = LOAD; ready and RESULT valid after the 9th edge. From an operand change seen in DONE: 10 edges (abort, LOAD, 8 shifts).
- Arithmetic: unsigned, exact, no overflow possible (max 255*255=65025 fits in 16 bits).
- Reset mid-operation: immediate return to reset values on that edge. Reset asserted together with an operand change: reset wins.
- ready is a level, not a pulse; no handshake or acknowledge input.

Optional Feature:
- Macro MULT_SHIFT_EARLY_EXIT_EN.
- Defined: in SHIFT, if the shifted B becomes zero (or cnt==7), go to DONE on that edge and load RESULT/ready there. A minimum of one SHIFT cycle always occurs.
  - Example: M2=4 completes after 3 shifts; M2=0 or M2=1 after 1 shift.
- Undefined: always exactly 8 SHIFT cycles, as above.
- RESULT values are identical either way; only latency differs.

Test Plan:
- Reset: hold RESET=1 for several cycles, then release → RESULT=0, ready=0 throughout reset and until the first completion.
- M1=5, M2=4 applied before RESET release → ready=1 with RESULT=20 at the 9th edge after release (4th with EARLY_EXIT_EN), held stable afterwards.
- In DONE, change M2 4→7 (M1=5) → ready drops on the next edge, RESULT stays 20 while busy, then RESULT=35 and ready=1 ten edges after the change.
- Extremes: 255×255 → 65025; 0×200 → 0; 200×0 → 0; 1×255 → 255; 128×2 → 256.
- Change M1 mid-SHIFT (after 3 shifts) from 10 to 3, M2=9 → computation restarts, final RESULT=27, never 90.
- Assert RESET mid-SHIFT for one cycle → RESULT=0, ready=0 on that edge; after release the multiply recomputes the current operands correctly.

Source files
------------

// File: rtl/mult_shift_8bits.sv
// mult_shift_8bits: sequential shift-and-add unsigned multiplier.
// One multiplier bit is retired per clock. The block captures its operands
// after reset and again whenever either operand changes, and raises the
// level `ready` once RESULT holds the product of the latched operands.
//
// Optional build macro: MULT_SHIFT_EARLY_EXIT_EN
//   defined   -> SHIFT ends as soon as the shifted multiplier is zero
//                (at least one SHIFT cycle always occurs)
//   undefined -> always exactly WIDTH SHIFT cycles
//
// Ports:
//   CLK     rising-edge clock
//   RESET   synchronous, active-high reset
//   M1      multiplicand, unsigned [WIDTH-1:0]
//   M2      multiplier, unsigned [WIDTH-1:0]
//   RESULT  product register [2*WIDTH-1:0]
//   ready   high while RESULT holds M1q*M2q
module mult_shift_8bits #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [WIDTH-1:0]   M1,
  input  logic [WIDTH-1:0]   M2,
  output logic [2*WIDTH-1:0] RESULT,
  output logic               ready
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [RW-1:0]    a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [RW-1:0]    p_q, p_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [WIDTH-1:0] m1_q, m1_nxt;
  logic [WIDTH-1:0] m2_q, m2_nxt;
  logic [RW-1:0]    result_nxt;
  logic             ready_nxt;

  logic             changed_c;
  logic [RW-1:0]    sum_c;
  logic [WIDTH-1:0] b_shift_c;
  logic             last_c;

  // Case inequality so undriven operands do not trigger a restart.
  assign changed_c = (M1 !== m1_q) || (M2 !== m2_q);
  assign sum_c     = p_q + (b_q[0] ? a_q : RW'(0));
  assign b_shift_c = b_q >> 1;

`ifdef MULT_SHIFT_EARLY_EXIT_EN
  assign last_c = (b_shift_c == '0) || (cnt_q == CNT_LAST);
`else
  assign last_c = (cnt_q == CNT_LAST);
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= LOAD;
    else       state_q <= state_nxt;
  end

  // Next-state logic; an operand change abandons any in-flight work.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      LOAD:    state_nxt = SHIFT;
      SHIFT: begin
        if (changed_c)   state_nxt = LOAD;
        else if (last_c) state_nxt = DONE;
      end
      DONE: begin
        if (changed_c)   state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    a_nxt      = a_q;
    b_nxt      = b_q;
    p_nxt      = p_q;
    cnt_nxt    = cnt_q;
    m1_nxt     = m1_q;
    m2_nxt     = m2_q;
    result_nxt = RESULT;
    ready_nxt  = ready;
    unique case (state_q)
      LOAD: begin
        a_nxt     = RW'(M1);
        b_nxt     = M2;
        p_nxt     = '0;
        cnt_nxt   = '0;
        m1_nxt    = M1;
        m2_nxt    = M2;
        ready_nxt = 1'b0;
      end
      SHIFT: begin
        if (changed_c) begin
          ready_nxt = 1'b0;
        end else begin
          p_nxt   = sum_c;
          a_nxt   = a_q << 1;
          b_nxt   = b_shift_c;
          cnt_nxt = CW'(cnt_q + 1'b1);
          if (last_c) begin
            result_nxt = sum_c;
            ready_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        if (changed_c) ready_nxt = 1'b0;
      end
      default: ready_nxt = 1'b0;
    endcase
  end

  // Datapath / output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      m1_q   <= '0;
      m2_q   <= '0;
      RESULT <= '0;
      ready  <= 1'b0;
    end else begin
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      p_q    <= p_nxt;
      cnt_q  <= cnt_nxt;
      m1_q   <= m1_nxt;
      m2_q   <= m2_nxt;
      RESULT <= result_nxt;
      ready  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_mult_shift_8bits.sv
module tb_mult_shift_8bits;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  M1 = 8'd0;
  logic [7:0]  M2 = 8'd0;
  logic [15:0] RESULT;
  logic        ready;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_result = 16'd0;

  mult_shift_8bits #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .M1(M1), .M2(M2), .RESULT(RESULT), .ready(ready)
  );

  always #5 CLK = ~CLK;

  // Number of SHIFT cycles the reference expects for a given multiplier.
  function automatic int shifts_for(input logic [7:0] m2);
`ifdef MULT_SHIFT_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 8; i++) if (m2[i]) n = i + 1;
    return n;
`else
    return 8;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] exp_r, input logic exp_rdy);
    checks++;
    assert (RESULT === exp_r) else begin
      errors++;
      $error("FAIL %s RESULT observed=%0d expected=%0d", tag, RESULT, exp_r);
    end
    checks++;
    assert (ready === exp_rdy) else begin
      errors++;
      $error("FAIL %s ready observed=%0b expected=%0b", tag, ready, exp_rdy);
    end
  endtask

  // Step `edges` clocks expecting busy (stale RESULT) until the last one.
  task automatic run_expect(input string tag, input int edges, input logic [15:0] product);
    for (int e = 1; e <= edges; e++) begin
      tick();
      if (e < edges) check_out({tag, "_busy"}, prev_result, 1'b0);
      else           check_out({tag, "_done"}, product, 1'b1);
    end
    prev_result = product;
  endtask

  // Apply new operands while in DONE: abort edge + LOAD + shifts.
  task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b);
    M1 = a;
    M2 = b;
    run_expect(tag, 2 + shifts_for(b), 16'(a) * 16'(b));
  endtask

  initial begin
    logic [7:0] ra, rb;

    // Reset held with operands already present.
    M1 = 8'd5; M2 = 8'd4; RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("reset", 16'd0, 1'b0);
    end

    // First computation after release: LOAD + shifts.
    RESET = 1'b0;
    run_expect("first_5x4", 1 + shifts_for(8'd4), 16'd20);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("hold_20", 16'd20, 1'b1);
    end

    // Change in DONE: ten edges (default build) to new product.
    apply("chg_5x7", 8'd5, 8'd7);
    tick();
    check_out("hold_35", 16'd35, 1'b1);

    // Extremes.
    apply("ext_255x255", 8'd255, 8'd255);
    apply("ext_0x200",   8'd0,   8'd200);
    apply("ext_200x0",   8'd200, 8'd0);
    apply("ext_1x255",   8'd1,   8'd255);
    apply("ext_128x2",   8'd128, 8'd2);

    // Mid-SHIFT operand change: 10x9 abandoned after 3 shifts, becomes 3x9.
    M1 = 8'd10; M2 = 8'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("abort_busy", prev_result, 1'b0);
    end
    M1 = 8'd3;
    run_expect("restart_3x9", 2 + shifts_for(8'd9), 16'd27);

    // Reset mid-SHIFT for one cycle, then recompute current operands.
    M1 = 8'd7; M2 = 8'd11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("pre_rst_busy", prev_result, 1'b0);
    end
    RESET = 1'b1;
    tick();
    check_out("mid_reset", 16'd0, 1'b0);
    RESET = 1'b0;
    prev_result = 16'd0;
    run_expect("post_rst_7x11", 1 + shifts_for(8'd11), 16'd77);

    // Randomized operand pairs against the arithmetic reference.
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (ra == M1 && rb == M2) ra = ra ^ 8'd1;
      apply("rand", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
